mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator-side load/store unit between the pipeline MEM stage and the data memory, a 512 x 32-bit word array with combinational read and write at the clock edge. It converts byte-addressed load/store requests of byte, halfword or word size into word-addressed memory accesses. Sub-word loads are extracted and extended on the returned word. Sub-word stores run a two-cycle read-modify-write and stall the pipeline for one cycle.

## Interface
- No parameters; the memory depth is fixed at 512 words (9-bit word address).
- clk  in  1  system clock; every state change happens on its rising edge
- reset  in  1  synchronous, active-high reset
- i_load  in  1  MEM-stage load request
- i_store  in  1  MEM-stage store request; wins if i_load is also high
- i_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- i_unsigned  in  1  zero-extend sub-word loads when high, sign-extend when low
- i_addr  in  32  byte address; bits [10:2] select the word, bits [31:11] are ignored
- i_wdata  in  32  store data, right-aligned
- o_rdata  out  32  load result, extended; 0 when there is no valid load
- o_stall  out  1  freeze the pipeline; the request must stay stable while this is high
- o_misalign  out  1  request is misaligned; the access is dropped
- o_mem_address  out  9  word address to memory, i_addr[10:2]
- o_mem_write_data  out  32  write word to memory
- o_mem_write  out  1  memory write enable
- o_mem_read  out  1  memory read enable
- i_mem_read_data  in  32  memory read word, valid in the same cycle as the address

## Operation
- FSM has two states: IDLE and RMW_WR. After reset the state is IDLE.
- Misaligned request: halfword with i_addr[0]=1, or word with i_addr[1:0]≠0.
  - o_misalign=1 in the same cycle; memory enables stay 0 and o_stall stays 0.
  - o_rdata=0.
- Load (IDLE):
  - o_mem_read=1; o_rdata is the selected lane, extended.
  - Byte lane is i_addr[1:0] (lane 0 = bits [7:0]); halfword lane is i_addr[1].
  - Single cycle, no stall.
- Word store (IDLE): o_mem_write=1, o_mem_write_data=i_wdata, single cycle, no stall.
- Sub-word store, IDLE cycle:
  - o_mem_read=1 and o_stall=1.
  - The fetched word is captured in old_q; go to RMW_WR.
- Sub-word store, RMW_WR cycle:
  - o_mem_write=1 and o_stall=0.
  - o_mem_write_data = old_q with the target lane replaced by the low bits of i_wdata.
  - Return to IDLE.
- The read-to-write path is registered by decision; there is no combinational merge from the memory read data into the write data.
- No request (i_load=i_store=0): all memory enables 0, o_mem_write_data=0, o_rdata=0.
- Reset values: every output is 0, old_q=0, state=IDLE.

## Timing
- Load and word-store latency is 0 cycles; memory write data is committed at the rising edge that ends the request cycle.
- Sub-word store takes 2 cycles. o_stall is high in cycle 1 only, and memory is updated at the edge that ends cycle 2.
- Reset during RMW_WR:
  - o_mem_write is forced to 0 in that cycle, so no partial write occurs.
  - The state is IDLE on the next cycle.
- Back-to-back sub-word stores: the second store enters IDLE the cycle after RMW_WR. Throughput is 1 store per 2 cycles.
- A load that follows a store to the same word sees the new data, because memory is written at the edge before the load cycle.
- o_misalign is combinational and is never high while in RMW_WR.

## Structure
- Shared package mem_pkg holds:
  - size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encoding: IDLE, RMW_WR
  - the misalignment predicate
- Sub-module byte_lane_merge (combinational) provides:
  - merge(old, wdata, size, addr[1:0]) → write word
  - extract(word, size, unsigned, addr[1:0]) → load result
- The top level holds the FSM, the old_q register and the memory-side muxing.

## Test plan
- Word store then word load: store 0xDEADBEEF at addr 0x10, then load from addr 0x10.
  - Store: o_mem_write=1 with word address 4, no stall.
  - Load: o_rdata=0xDEADBEEF in the same cycle.
- Signed byte load: memory word 0x80FF7F01 at word 2, load byte at addr 0x0B (lane 3), i_unsigned=0.
  - Expect o_rdata=0xFFFFFF80.
  - Same load with i_unsigned=1 expects 0x00000080.
- Halfword RMW: word 1 holds 0x11223344; store halfword 0xABCD at addr 0x06.
  - Cycle 1: o_stall=1, o_mem_read=1, no write.
  - Cycle 2: o_mem_write=1 with data 0xABCD3344.
  - A following load of word 1 returns 0xABCD3344.
- Misalignment: halfword store at addr 0x03 and word load at addr 0x02.
  - Expect o_misalign=1, o_mem_write=0, o_stall=0, o_rdata=0, and memory unchanged.
- Reset in RMW_WR: assert reset during cycle 2 of a byte store to a word holding 0x00000000.
  - Expect o_mem_write=0 and the word still 0x00000000.
  - All outputs 0 and state IDLE afterwards.
- Back-to-back stores: byte stores 0xAA at addr 0x20 then 0xBB at addr 0x21 (word initially 0).
  - o_stall pattern 1,0,1,0.
  - Final word 0x0000BBAA.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states,
// request record and the misalignment predicate.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;

    localparam int NUM_LANES   = 4;
    localparam int LANE_W      = 8;
    localparam int WORD_ADDR_W = 9;

    typedef struct packed {
        logic        load;
        logic        store;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Size 2'b11 behaves as a word access, so it needs full word alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = offset[0];
            default: is_misaligned = |offset;
        endcase
    endfunction
endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane logic: merges store data into an old word and extracts/extends
// the addressed lane of a loaded word.
module byte_lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] extracted
);
    logic [LANE_W-1:0] byte_sel;
    logic [15:0]       half_sel;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam logic [1:0] LANE = 2'(g);
        logic              lane_en;
        logic [LANE_W-1:0] lane_src;

        // Sub-word store data is right-aligned, so a halfword lane picks its byte by g%2.
        always_comb begin
            case (size)
                SZ_BYTE: begin
                    lane_en  = (offset == LANE);
                    lane_src = wdata[LANE_W-1:0];
                end
                SZ_HALF: begin
                    lane_en  = (offset[1] == LANE[1]);
                    lane_src = wdata[(g % 2)*LANE_W +: LANE_W];
                end
                default: begin
                    lane_en  = 1'b1;
                    lane_src = wdata[g*LANE_W +: LANE_W];
                end
            endcase
        end

        assign merged[g*LANE_W +: LANE_W] = lane_en ? lane_src : old_word[g*LANE_W +: LANE_W];
    end

    assign byte_sel = rd_word[{offset, 3'b000} +: LANE_W];
    assign half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (size)
            SZ_BYTE: extracted = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: extracted = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: extracted = rd_word;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a 512-word data memory; sub-word stores
// run as a registered two-cycle read-modify-write.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic                   i_store,
    input  logic [1:0]             i_size,
    input  logic                   i_unsigned,
    input  logic [31:0]            i_addr,
    input  logic [31:0]            i_wdata,
    output logic [31:0]            o_rdata,
    output logic                   o_stall,
    output logic                   o_misalign,
    output logic [WORD_ADDR_W-1:0] o_mem_address,
    output logic [31:0]            o_mem_write_data,
    output logic                   o_mem_write,
    output logic                   o_mem_read,
    input  logic [31:0]            i_mem_read_data
);
    mem_req_t    req;
    logic [0:0]  state_q, state_d;
    logic [31:0] old_q;
    logic [31:0] merged, extracted;
    logic        misalign, sub_word;
    logic        addr_hi_unused;

    assign req = '{load: i_load, store: i_store, size: i_size, is_unsigned: i_unsigned,
                   addr: i_addr, wdata: i_wdata};
    assign addr_hi_unused = ^req.addr[31:11];

    assign misalign = (req.load | req.store) & is_misaligned(req.size, req.addr[1:0]);
    assign sub_word = (req.size == SZ_BYTE) | (req.size == SZ_HALF);

    byte_lane_merge u_lanes (
        .old_word    (old_q),
        .wdata       (req.wdata),
        .rd_word     (i_mem_read_data),
        .size        (req.size),
        .offset      (req.addr[1:0]),
        .is_unsigned (req.is_unsigned),
        .merged      (merged),
        .extracted   (extracted)
    );

    // Reset gates every output, which also suppresses the RMW write if reset lands in RMW_WR.
    always_comb begin
        state_d          = state_q;
        o_rdata          = '0;
        o_stall          = 1'b0;
        o_misalign       = 1'b0;
        o_mem_address    = req.addr[10:2];
        o_mem_write_data = '0;
        o_mem_write      = 1'b0;
        o_mem_read       = 1'b0;
        if (reset) begin
            o_mem_address = '0;
        end else if (state_q == RMW_WR) begin
            o_mem_write      = 1'b1;
            o_mem_write_data = merged;
            state_d          = IDLE;
        end else if (misalign) begin
            o_misalign = 1'b1;
        end else if (req.store) begin
            if (sub_word) begin
                o_mem_read = 1'b1;
                o_stall    = 1'b1;
                state_d    = RMW_WR;
            end else begin
                o_mem_write      = 1'b1;
                o_mem_write_data = req.wdata;
            end
        end else if (req.load) begin
            o_mem_read = 1'b1;
            o_rdata    = extracted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == RMW_WR)
                old_q <= i_mem_read_data;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single-cycle accesses plus
// hand-written RMW, reset-in-RMW and back-to-back store sequences.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_load, i_store, i_unsigned;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata;
    logic [31:0] o_rdata, o_mem_write_data, i_mem_read_data;
    logic        o_stall, o_misalign, o_mem_write, o_mem_read;
    logic [8:0]  o_mem_address;

    logic [31:0] mem [0:511];
    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] e_rdata;
        logic [31:0] e_wdata;
        logic [8:0]  e_maddr;
        logic        e_stall;
        logic        e_mis;
        logic        e_wr;
        logic        e_rd;
    } vec_t;

    vec_t vecs[$];

    mem_access_unit dut (
        .clk              (clk),
        .reset            (reset),
        .i_load           (i_load),
        .i_store          (i_store),
        .i_size           (i_size),
        .i_unsigned       (i_unsigned),
        .i_addr           (i_addr),
        .i_wdata          (i_wdata),
        .o_rdata          (o_rdata),
        .o_stall          (o_stall),
        .o_misalign       (o_misalign),
        .o_mem_address    (o_mem_address),
        .o_mem_write_data (o_mem_write_data),
        .o_mem_write      (o_mem_write),
        .o_mem_read       (o_mem_read),
        .i_mem_read_data  (i_mem_read_data)
    );

    always #5 clk = ~clk;

    assign i_mem_read_data = mem[o_mem_address];
    always @(posedge clk) if (o_mem_write) mem[o_mem_address] <= o_mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        i_load = ld; i_store = st; i_size = sz; i_unsigned = uns; i_addr = addr; i_wdata = wd;
        #1;
    endtask

    task automatic chk_outs(input string n, input logic [31:0] rd, input logic [31:0] wd,
                            input logic stall, input logic mis, input logic wr, input logic rdn);
        chk({n, ".rdata"},  o_rdata, rd);
        chk({n, ".wdata"},  o_mem_write_data, wd);
        chk({n, ".stall"},  32'(o_stall), 32'(stall));
        chk({n, ".mis"},    32'(o_misalign), 32'(mis));
        chk({n, ".write"},  32'(o_mem_write), 32'(wr));
        chk({n, ".read"},   32'(o_mem_read), 32'(rdn));
    endtask

    initial begin
        reset = 1'b1;
        i_load = 0; i_store = 0; i_size = 0; i_unsigned = 0; i_addr = 0; i_wdata = 0;

        //                name         ld st sz     u  addr          wdata          e_rdata        e_wdata        maddr st mi wr rd
        vecs.push_back('{"st_w00",     0, 1, 2'b10, 0, 32'h00,       32'h0,         32'h0,         32'h0,         9'd0, 0, 0, 1, 0});
        vecs.push_back('{"st_w10",     0, 1, 2'b10, 0, 32'h10,       32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  9'd4, 0, 0, 1, 0});
        vecs.push_back('{"ld_w10",     1, 0, 2'b10, 0, 32'h10,       32'h0,         32'hDEADBEEF,  32'h0,         9'd4, 0, 0, 0, 1});
        vecs.push_back('{"st_w08",     0, 1, 2'b10, 0, 32'h08,       32'h80FF7F01,  32'h0,         32'h80FF7F01,  9'd2, 0, 0, 1, 0});
        vecs.push_back('{"st_w04",     0, 1, 2'b10, 0, 32'h04,       32'h11223344,  32'h0,         32'h11223344,  9'd1, 0, 0, 1, 0});
        vecs.push_back('{"st_w20",     0, 1, 2'b10, 0, 32'h20,       32'h0,         32'h0,         32'h0,         9'd8, 0, 0, 1, 0});
        vecs.push_back('{"st_w40",     0, 1, 2'b10, 0, 32'h40,       32'h0,         32'h0,         32'h0,         9'd16,0, 0, 1, 0});
        vecs.push_back('{"ld_b0b_s",   1, 0, 2'b00, 0, 32'h0B,       32'h0,         32'hFFFFFF80,  32'h0,         9'd2, 0, 0, 0, 1});
        vecs.push_back('{"ld_b0b_u",   1, 0, 2'b00, 1, 32'h0B,       32'h0,         32'h00000080,  32'h0,         9'd2, 0, 0, 0, 1});
        vecs.push_back('{"ld_b08_s",   1, 0, 2'b00, 0, 32'h08,       32'h0,         32'h00000001,  32'h0,         9'd2, 0, 0, 0, 1});
        vecs.push_back('{"ld_b09_s",   1, 0, 2'b00, 0, 32'h09,       32'h0,         32'h0000007F,  32'h0,         9'd2, 0, 0, 0, 1});
        vecs.push_back('{"ld_b0a_s",   1, 0, 2'b00, 0, 32'h0A,       32'h0,         32'hFFFFFFFF,  32'h0,         9'd2, 0, 0, 0, 1});
        vecs.push_back('{"ld_h0a_s",   1, 0, 2'b01, 0, 32'h0A,       32'h0,         32'hFFFF80FF,  32'h0,         9'd2, 0, 0, 0, 1});
        vecs.push_back('{"ld_h0a_u",   1, 0, 2'b01, 1, 32'h0A,       32'h0,         32'h000080FF,  32'h0,         9'd2, 0, 0, 0, 1});
        vecs.push_back('{"ld_h08_s",   1, 0, 2'b01, 0, 32'h08,       32'h0,         32'h00007F01,  32'h0,         9'd2, 0, 0, 0, 1});
        vecs.push_back('{"ld_sz3",     1, 0, 2'b11, 0, 32'h10,       32'h0,         32'hDEADBEEF,  32'h0,         9'd4, 0, 0, 0, 1});
        vecs.push_back('{"ld_hi_ign",  1, 0, 2'b10, 0, 32'hFFFFF810, 32'h0,         32'hDEADBEEF,  32'h0,         9'd4, 0, 0, 0, 1});
        vecs.push_back('{"ld_st_both", 1, 1, 2'b10, 0, 32'h44,       32'h12345678,  32'h0,         32'h12345678,  9'd17,0, 0, 1, 0});
        vecs.push_back('{"mis_ld_w02", 1, 0, 2'b10, 0, 32'h02,       32'h0,         32'h0,         32'h0,         9'd0, 0, 1, 0, 0});
        vecs.push_back('{"mis_st_h03", 0, 1, 2'b01, 0, 32'h03,       32'h1234,      32'h0,         32'h0,         9'd0, 0, 1, 0, 0});
        vecs.push_back('{"mis_ld_h05", 1, 0, 2'b01, 0, 32'h05,       32'h0,         32'h0,         32'h0,         9'd1, 0, 1, 0, 0});
        vecs.push_back('{"mis_st_w11", 0, 1, 2'b11, 0, 32'h11,       32'hCAFE,      32'h0,         32'h0,         9'd4, 0, 1, 0, 0});
        vecs.push_back('{"idle",       0, 0, 2'b10, 0, 32'h10,       32'h55,        32'h0,         32'h0,         9'd4, 0, 0, 0, 0});

        // Reset held with a live load request: every output must be 0.
        drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
        chk_outs("reset", 32'h0, 32'h0, 0, 0, 0, 0);
        chk("reset.maddr", 32'(o_mem_address), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd);
            chk_outs(vecs[i].name, vecs[i].e_rdata, vecs[i].e_wdata, vecs[i].e_stall,
                     vecs[i].e_mis, vecs[i].e_wr, vecs[i].e_rd);
            if (vecs[i].e_wr || vecs[i].e_rd)
                chk({vecs[i].name, ".maddr"}, 32'(o_mem_address), 32'(vecs[i].e_maddr));
        end
        chk("mem0_untouched", mem[0], 32'h0);
        chk("mem1_untouched", mem[1], 32'h11223344);
        chk("mem4_untouched", mem[4], 32'hDEADBEEF);

        // Halfword read-modify-write into word 1.
        drive(0, 1, 2'b01, 0, 32'h06, 32'h0000ABCD);
        chk_outs("rmw_c1", 32'h0, 32'h0, 1, 0, 0, 1);
        chk("rmw_c1.maddr", 32'(o_mem_address), 32'd1);
        drive(0, 1, 2'b01, 0, 32'h06, 32'h0000ABCD);
        chk_outs("rmw_c2", 32'h0, 32'hABCD3344, 0, 0, 1, 0);
        chk("rmw_c2.maddr", 32'(o_mem_address), 32'd1);
        drive(1, 0, 2'b10, 0, 32'h04, 32'h0);
        chk("rmw_reload", o_rdata, 32'hABCD3344);

        // Reset lands in the write cycle of a byte store to word 16.
        drive(0, 1, 2'b00, 0, 32'h40, 32'h55);
        chk("rst_rmw_c1.stall", 32'(o_stall), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_outs("rst_rmw_c2", 32'h0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        i_load = 0; i_store = 0;
        #1;
        chk_outs("post_rst", 32'h0, 32'h0, 0, 0, 0, 0);
        chk("rst_rmw_mem16", mem[16], 32'h0);

        // Back-to-back byte stores into word 8; first stall also shows the FSM is back in IDLE.
        drive(0, 1, 2'b00, 0, 32'h20, 32'hAA);
        chk("b2b_c1.stall", 32'(o_stall), 32'd1);
        drive(0, 1, 2'b00, 0, 32'h20, 32'hAA);
        chk("b2b_c2.stall", 32'(o_stall), 32'd0);
        chk("b2b_c2.wdata", o_mem_write_data, 32'h000000AA);
        drive(0, 1, 2'b00, 0, 32'h21, 32'hBB);
        chk("b2b_c3.stall", 32'(o_stall), 32'd1);
        drive(0, 1, 2'b00, 0, 32'h21, 32'hBB);
        chk("b2b_c4.stall", 32'(o_stall), 32'd0);
        chk("b2b_c4.wdata", o_mem_write_data, 32'h0000BBAA);
        drive(1, 0, 2'b10, 0, 32'h20, 32'h0);
        chk("b2b_reload", o_rdata, 32'h0000BBAA);
        chk("b2b_mem8", mem[8], 32'h0000BBAA);

        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
